// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage: shift-add multiply,
// restoring divide, early out for divide-by-zero and signed overflow.
module muldiv_iter_unit #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [REG_W-1:0] rd_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [REG_W-1:0] rd_out,
  output logic             stall_req
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONES     = '1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2:0]          op_reg;
  logic [REG_W-1:0]    rd_reg;
  logic [XLEN-1:0]     opnd_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic                neg_reg;
  logic                spec_reg;
  logic [XLEN-1:0]     spec_res_reg;
  logic [XLEN-1:0]     result_reg;
  logic [REG_W-1:0]    rd_out_reg;
  logic                done_reg;

  // The done cycle still counts as busy so a start there is dropped.
  logic accept;
  assign busy      = (state_reg != IDLE) || done_reg;
  assign accept    = (state_reg == IDLE) && !done_reg && start && !flush;
  assign stall_req = start || busy;
  assign done      = done_reg;
  assign result    = result_reg;
  assign rd_out    = rd_out_reg;

  // Operand decode at capture time
  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] abs1, abs2;
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    sgn1     = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn2     = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    s1       = sgn1 && rs1_val[XLEN-1];
    s2       = sgn2 && rs2_val[XLEN-1];
    abs1     = s1 ? -rs1_val : rs1_val;
    abs2     = s2 ? -rs2_val : rs2_val;
    is_div   = op[2];
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1_val == MIN_VAL) && (rs2_val == ONES);
    special  = div_zero || div_ovf;
    spec_val = '0;
    if (div_zero)
      spec_val = op[1] ? rs1_val : ONES;
    else if (div_ovf)
      spec_val = op[1] ? '0 : rs1_val;
  end

  // One radix-2 step: low half holds multiplier / dividend bits being consumed.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] iter_acc;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = acc_reg[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (!op_reg[2])
      iter_acc = {mul_sum, acc_reg[XLEN-1:1]};
    else if (div_diff[XLEN])
      iter_acc = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    else
      iter_acc = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result selection while leaving FIN
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, final_res;

  always_comb begin
    prod_fin = neg_reg ? -acc_reg : acc_reg;
    quo_fin  = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fin  = neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    if (spec_reg)
      final_res = spec_res_reg;
    else if (op_reg[2])
      final_res = op_reg[1] ? rem_fin : quo_fin;
    else if (op_reg == OP_MUL)
      final_res = prod_fin[XLEN-1:0];
    else
      final_res = prod_fin[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = special ? FIN : CALC;
      CALC:    if (cnt_reg == LAST_CNT) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      rd_reg       <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      neg_reg      <= 1'b0;
      spec_reg     <= 1'b0;
      spec_res_reg <= '0;
      result_reg   <= '0;
      rd_out_reg   <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == FIN) && !flush;
      if ((state_reg == FIN) && !flush) begin
        result_reg <= final_res;
        rd_out_reg <= rd_reg;
      end
      if (accept) begin
        op_reg       <= op;
        rd_reg       <= rd_in;
        cnt_reg      <= '0;
        opnd_reg     <= is_div ? abs2 : abs1;
        acc_reg      <= {{XLEN{1'b0}}, is_div ? abs1 : abs2};
        // Remainder follows the dividend; everything else follows the product/quotient sign.
        neg_reg      <= (is_div && op[1]) ? s1 : (s1 ^ s2);
        spec_reg     <= special;
        spec_res_reg <= spec_val;
      end else if ((state_reg == CALC) && !flush) begin
        acc_reg <= iter_acc;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: directed cases, flush/reset
// scenarios and randomized ops against a plain-arithmetic reference.
module tb_muldiv_iter_unit;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic             clk1 = 1'b0;
  logic             rst_n, start, flush;
  logic [2:0]       op;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic [REG_W-1:0] rd_in;
  logic             busy, done, stall_req;
  logic [XLEN-1:0]  result;
  logic [REG_W-1:0] rd_out;

  muldiv_iter_unit #(.XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .busy(busy),
    .done(done), .result(result), .rd_out(rd_out), .stall_req(stall_req)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          e0;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] last_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    int sa, sb_;
    sa  = int'(a);
    sb_ = int'(b);
    case (o)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb_); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb_);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb_);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk1) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got result %h rd %0d, expected no done", result, rd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, " result"}, result, e.res);
        chk({e.name, " rd_out"}, 32'(rd_out), 32'(e.rd));
        chk({e.name, " latency"}, 32'(cyc - e.e0), 32'(e.lat));
        $display("[TB] txn %s result=%h rd=%0d latency=%0d", e.name, result, rd_out, cyc - e.e0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_done, input string nm);
    exp_t e;
    @(negedge clk1);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    #1 chk({nm, " stall_req at start"}, 32'(stall_req), 32'd1);
    if (expect_done) begin
      e.res = ref_model(o, a, b); e.rd = rd; e.e0 = cyc + 1;
      e.lat = ref_lat(o, a, b); e.name = nm;
      sb.push_back(e);
      last_res = e.res;
    end
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || sb.size() != 0) && n < maxc) begin
      @(negedge clk1);
      n++;
    end
    if (n >= maxc) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait_idle timeout: got busy after %0d cycles, expected idle", n);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit all_busy;
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    rs1_val = '0; rs2_val = '0; rd_in = '0; last_res = '0;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);
    chk("idle stall_req", 32'(stall_req), 32'd0);

    // MUL with busy held every cycle up to and including done
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b1, "MUL 7*-3");
    all_busy = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40 && !saw_done; i++) begin
      all_busy &= busy;
      all_busy &= stall_req;
      if (done) saw_done = 1'b1;
      else @(negedge clk1);
    end
    chk("MUL busy through done", 32'(all_busy && saw_done), 32'd1);
    @(negedge clk1);
    chk("MUL busy after done", 32'(busy), 32'd0);

    issue(3'd1, MINV, MINV, 5'd1, 1'b1, "MULH min*min");              wait_idle(60);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, "MULHU");   wait_idle(60);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b1, "MULHSU -1*2");     wait_idle(60);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, "DIV -7/2");        wait_idle(60);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, "REM -7/2");        wait_idle(60);
    issue(3'd5, 32'd100, 32'd7, 5'd6, 1'b1, "DIVU 100/7");            wait_idle(60);
    issue(3'd7, 32'd100, 32'd7, 5'd7, 1'b1, "REMU 100/7");            wait_idle(60);
    issue(3'd4, 32'd5, 32'd0, 5'd8, 1'b1, "DIV 5/0");                 wait_idle(60);
    issue(3'd7, 32'd5, 32'd0, 5'd10, 1'b1, "REMU 5/0");               wait_idle(60);
    issue(3'd4, MINV, 32'hFFFF_FFFF, 5'd11, 1'b1, "DIV ovf");         wait_idle(60);
    issue(3'd6, MINV, 32'hFFFF_FFFF, 5'd12, 1'b1, "REM ovf");         wait_idle(60);

    // Flushed DIVU with an ignored second start in between
    issue(3'd5, 32'd1000, 32'd3, 5'd13, 1'b0, "DIVU flushed");
    repeat (3) @(negedge clk1);
    op = 3'd0; rs1_val = 32'd11; rs2_val = 32'd11; rd_in = 5'd14; start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    repeat (4) @(negedge clk1);
    flush = 1'b1;
    @(negedge clk1);
    flush = 1'b0;
    chk("flush busy low", 32'(busy), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk1);
      saw_done |= done;
    end
    chk("flush no done", 32'(saw_done), 32'd0);
    chk("flush result held", result, last_res);
    issue(3'd0, 32'd3, 32'd4, 5'd15, 1'b1, "MUL 3*4");                wait_idle(60);

    // Reset in the middle of a DIV
    issue(3'd4, 32'd77, 32'd5, 5'd16, 1'b0, "DIV reset");
    repeat (18) @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset result", result, 32'd0);
    chk("midreset rd_out", 32'(rd_out), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk1);
      saw_done |= done;
    end
    chk("midreset no done", 32'(saw_done), 32'd0);
    issue(3'd7, 32'd9, 32'd4, 5'd17, 1'b1, "REMU 9/4");               wait_idle(60);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 80; i++) begin
      logic [2:0] ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, 5'($urandom_range(0, 31)), 1'b1, $sformatf("rnd%0d op%0d %h,%h", i, ro, ra, rb));
      wait_idle(60);
    end

    repeat (3) @(negedge clk1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
